// File: rtl/superh16_free_list.sv
// superh16_free_list -- physical-register free list with R10K-style recovery.
//
// Tags ARCH_REGS..PHYS_REGS-1 start in a circular FIFO of CAP = PHYS_REGS-ARCH_REGS
// slots. Rename pops up to ISSUE_WIDTH tags per cycle (all-or-nothing), retirement
// pushes old tags back, and a flush rewinds the speculative head to the committed
// head so every speculatively popped tag is reissued.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   alloc_req_i         per-lane allocation request
//   alloc_tag_o         per-lane granted tag, compacted, combinational (0 if idle)
//   alloc_ready_o       at least ISSUE_WIDTH tags available
//   commit_valid_i      per-lane retire valid
//   commit_has_dst_i    retiring instruction owns a destination tag
//   commit_old_tag_i    per-lane tag to return to the list
//   flush_i             exception / mispredict recovery
//   free_count_o        registered speculative free count
//   double_free_err_o   sticky double-free flag
//
// Optional build macro: SUPERH16_FREELIST_CHECK_EN enables the on_list tracking
// vector and double-free detection; without it double_free_err_o is tied low.
module superh16_free_list #(
  parameter int PHYS_REGS     = 512,
  parameter int PHYS_REG_BITS = 9,
  parameter int ARCH_REGS     = 64,
  parameter int ISSUE_WIDTH   = 12,
  parameter int RETIRE_WIDTH  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ISSUE_WIDTH-1:0]   alloc_req_i,
  output logic [PHYS_REG_BITS-1:0] alloc_tag_o [ISSUE_WIDTH],
  output logic                     alloc_ready_o,
  input  logic [RETIRE_WIDTH-1:0]  commit_valid_i,
  input  logic [RETIRE_WIDTH-1:0]  commit_has_dst_i,
  input  logic [PHYS_REG_BITS-1:0] commit_old_tag_i [RETIRE_WIDTH],
  input  logic                     flush_i,
  output logic [PHYS_REG_BITS:0]   free_count_o,
  output logic                     double_free_err_o
);

  localparam int CAP   = PHYS_REGS - ARCH_REGS;
  localparam int PTR_W = $clog2(CAP);
  localparam int CNT_W = PHYS_REG_BITS + 1;

  // Modular add; n is always far below CAP so one conditional subtract suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W-1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {1'b0, n};
    if (s >= (PTR_W+1)'(CAP)) s = s - (PTR_W+1)'(CAP);
    else                      s = s;
    return s[PTR_W-1:0];
  endfunction

  // Modular distance a - b.
  function automatic logic [PTR_W-1:0] ptr_sub(input logic [PTR_W-1:0] a,
                                               input logic [PTR_W-1:0] b);
    logic [PTR_W:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + (PTR_W+1)'(CAP) - {1'b0, b};
    return s[PTR_W-1:0];
  endfunction

  logic [PHYS_REG_BITS-1:0] fifo_q [CAP];
  logic [PTR_W-1:0] spec_head_q, spec_head_d;
  logic [PTR_W-1:0] commit_head_q, commit_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] spec_cnt_q, spec_cnt_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;

  logic [PTR_W-1:0] n_alloc_s, n_free_s;
  logic [PTR_W-1:0] wr_idx_s [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] wr_en_s;
  logic pop_s;

  assign alloc_ready_o = (spec_cnt_q >= CNT_W'(ISSUE_WIDTH));
  assign free_count_o  = spec_cnt_q;
  assign pop_s         = alloc_ready_o & ~flush_i;

  // Compacted read: lane i takes the slot offset by the number of requesters below it.
  always_comb begin
    logic [PTR_W-1:0] rank;
    rank = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      alloc_tag_o[i] = '0;
      if (alloc_req_i[i]) begin
        alloc_tag_o[i] = fifo_q[ptr_add(spec_head_q, rank)];
        rank = rank + PTR_W'(1);
      end else begin
        rank = rank;
      end
    end
    n_alloc_s = rank;
  end

  // Compacted write slots for returned tags, in lane order from the tail.
  always_comb begin
    logic [PTR_W-1:0] rank;
    rank = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      wr_en_s[j]  = commit_valid_i[j] & commit_has_dst_i[j];
      wr_idx_s[j] = ptr_add(tail_q, rank);
      if (wr_en_s[j]) rank = rank + PTR_W'(1);
      else            rank = rank;
    end
    n_free_s = rank;
  end

  // Pointer and counter next state; a flush rewinds to the post-commit head.
  always_comb begin
    tail_d        = ptr_add(tail_q, n_free_s);
    commit_head_d = ptr_add(commit_head_q, n_free_s);
    commit_cnt_d  = commit_cnt_q;
    if (flush_i) begin
      spec_head_d = commit_head_d;
      spec_cnt_d  = commit_cnt_q;
    end else if (pop_s) begin
      spec_head_d = ptr_add(spec_head_q, n_alloc_s);
      spec_cnt_d  = spec_cnt_q + CNT_W'(n_free_s) - CNT_W'(n_alloc_s);
    end else begin
      spec_head_d = spec_head_q;
      spec_cnt_d  = spec_cnt_q + CNT_W'(n_free_s);
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      spec_cnt_q    <= CNT_W'(CAP);
      commit_cnt_q  <= CNT_W'(CAP);
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      spec_cnt_q    <= spec_cnt_d;
      commit_cnt_q  <= commit_cnt_d;
    end
  end

  // Tag storage: reset image holds the non-architectural tags in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CAP; k++) fifo_q[k] <= PHYS_REG_BITS'(ARCH_REGS + k);
    end else begin
      for (int j = 0; j < RETIRE_WIDTH; j++) begin
        if (wr_en_s[j]) fifo_q[wr_idx_s[j]] <= commit_old_tag_i[j];
      end
    end
  end

`ifdef SUPERH16_FREELIST_CHECK_EN
  logic [PHYS_REGS-1:0] on_list_q, on_list_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     restore_len_s;

  // Membership tracking: pops clear, frees set (flagging repeats), flush re-sets
  // every slot between the post-commit head and the old speculative head.
  always_comb begin
    on_list_d     = on_list_q;
    err_d         = err_q;
    restore_len_s = commit_cnt_q - spec_cnt_q - CNT_W'(n_free_s);
    if (pop_s) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (alloc_req_i[i]) on_list_d[alloc_tag_o[i]] = 1'b0;
        else                on_list_d = on_list_d;
      end
    end else begin
      on_list_d = on_list_d;
    end
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      if (wr_en_s[j]) begin
        if (on_list_d[commit_old_tag_i[j]] ||
            ((commit_old_tag_i[j] < PHYS_REG_BITS'(ARCH_REGS)) &&
             (spec_cnt_q == CNT_W'(CAP)))) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        on_list_d[commit_old_tag_i[j]] = 1'b1;
      end else begin
        err_d = err_d;
      end
    end
    if (flush_i) begin
      for (int k = 0; k < CAP; k++) begin
        if (CNT_W'(ptr_sub(PTR_W'(k), commit_head_d)) < restore_len_s)
          on_list_d[fifo_q[k]] = 1'b1;
        else
          on_list_d = on_list_d;
      end
    end else begin
      on_list_d = on_list_d;
    end
  end

  // Membership vector and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_list_q <= {{CAP{1'b1}}, {ARCH_REGS{1'b0}}};
      err_q     <= 1'b0;
    end else begin
      on_list_q <= on_list_d;
      err_q     <= err_d;
    end
  end

  assign double_free_err_o = err_q;
`else
  assign double_free_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_superh16_free_list.sv
// Directed, table-driven bench for superh16_free_list.
module tb_superh16_free_list;

  localparam int IW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] alloc_req = '0;
  logic [8:0]  alloc_tag [IW];
  logic        alloc_ready;
  logic [11:0] commit_valid = '0;
  logic [11:0] commit_has_dst = '0;
  logic [8:0]  c_tag [IW];
  logic        flush = 1'b0;
  logic [9:0]  free_count;
  logic        double_free_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  superh16_free_list dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_req_i      (alloc_req),
    .alloc_tag_o      (alloc_tag),
    .alloc_ready_o    (alloc_ready),
    .commit_valid_i   (commit_valid),
    .commit_has_dst_i (commit_has_dst),
    .commit_old_tag_i (c_tag),
    .flush_i          (flush),
    .free_count_o     (free_count),
    .double_free_err_o(double_free_err)
  );

  typedef struct packed {
    logic [11:0] req;
    logic [11:0] cv;
    logic [11:0] hd;
    logic [8:0]  tbase;
    logic        fl;
    logic [8:0]  tag0;
    logic [9:0]  fc;
    logic        rdy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_cmt(input logic [11:0] m, input int base);
    commit_valid   = m;
    commit_has_dst = m;
    for (int k = 0; k < IW; k++) c_tag[k] = 9'(base + k);
  endtask

  task automatic idle_inputs();
    alloc_req = '0;
    flush     = 1'b0;
    set_cmt(12'h000, 0);
  endtask

  // Advance one clock; returns at posedge+1 with registered outputs settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    //              req      cv       hd       tbase  fl    tag0   fc      rdy
    vecs[0] = '{12'h000, 12'h000, 12'h000, 9'd0,  1'b0, 9'd0,  10'd448, 1'b1};
    vecs[1] = '{12'h212, 12'h000, 12'h000, 9'd0,  1'b0, 9'd64, 10'd445, 1'b1};
    vecs[2] = '{12'hFFF, 12'h000, 12'h000, 9'd0,  1'b0, 9'd67, 10'd433, 1'b1};
    vecs[3] = '{12'h000, 12'h007, 12'h005, 9'd1,  1'b0, 9'd0,  10'd435, 1'b1};
    vecs[4] = '{12'hFFF, 12'h001, 12'h001, 9'd7,  1'b0, 9'd79, 10'd424, 1'b1};
    vecs[5] = '{12'hFFF, 12'h003, 12'h003, 9'd10, 1'b1, 9'd0,  10'd448, 1'b1};
    vecs[6] = '{12'h001, 12'h000, 12'h000, 9'd0,  1'b0, 9'd69, 10'd447, 1'b1};
    vecs[7] = '{12'h800, 12'h000, 12'h000, 9'd0,  1'b0, 9'd70, 10'd446, 1'b1};

    // Reset image.
    do_reset();
    chk("rst free_count", free_count, 448);
    chk("rst alloc_ready", alloc_ready, 1);
    chk("rst double_free_err", double_free_err, 0);

    // Table: compaction, simultaneous pop/free, flush with frees.
    for (int v = 0; v < 8; v++) begin
      int rank;
      alloc_req      = vecs[v].req;
      commit_valid   = vecs[v].cv;
      commit_has_dst = vecs[v].hd;
      for (int k = 0; k < IW; k++) c_tag[k] = vecs[v].tbase + 9'(k);
      flush = vecs[v].fl;
      #2;
      rank = 0;
      if (!vecs[v].fl) begin
        for (int i = 0; i < IW; i++) begin
          if (vecs[v].req[i]) begin
            chk($sformatf("v%0d alloc_tag[%0d]", v, i), alloc_tag[i], vecs[v].tag0 + rank);
            rank++;
          end
        end
      end
      tick();
      chk($sformatf("v%0d free_count", v), free_count, vecs[v].fc);
      chk($sformatf("v%0d alloc_ready", v), alloc_ready, vecs[v].rdy);
    end

    // Flush restores everything popped; 64..68 were committed and are not reissued.
    do_reset();
    alloc_req = 12'hFFF;
    #2;
    for (int i = 0; i < IW; i++) chk($sformatf("full pop tag[%0d]", i), alloc_tag[i], 64 + i);
    tick();
    alloc_req = 12'h000;
    set_cmt(12'h01F, 1);
    tick();
    chk("after commit free_count", free_count, 441);
    set_cmt(12'h000, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("after flush free_count", free_count, 448);
    alloc_req = 12'hFFF;
    #2;
    for (int i = 0; i < IW; i++) chk($sformatf("post flush tag[%0d]", i), alloc_tag[i], 69 + i);
    tick();
    chk("post flush pop free_count", free_count, 436);

    // Drain to below one full group; all-or-nothing grant then holds.
    do_reset();
    alloc_req = 12'hFFF;
    for (int g = 0; g < 37; g++) begin
      tick();
      if (g == 35) begin
        chk("drain fc 16", free_count, 16);
        chk("drain ready at 16", alloc_ready, 1);
      end
    end
    chk("drain free_count", free_count, 4);
    chk("drain alloc_ready", alloc_ready, 0);
    tick();
    chk("blocked pop free_count", free_count, 4);
    // Asynchronous reset in mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst free_count", free_count, 448);
    chk("async rst alloc_ready", alloc_ready, 1);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Wrap: lap one pops and frees in lock-step so tail follows the head.
    do_reset();
    for (int c = 0; c < 36; c++) begin
      alloc_req = 12'hFFF;
      set_cmt(12'hFFF, (c == 0) ? 0 : 64 + 12 * (c - 1));
      #2;
      if (c == 0 || c == 35) begin
        chk($sformatf("lap c%0d tag0", c), alloc_tag[0], 64 + 12 * c);
        chk($sformatf("lap c%0d tag11", c), alloc_tag[11], 75 + 12 * c);
      end
      tick();
    end
    alloc_req = 12'h0FF;
    set_cmt(12'h0FF, 484);
    #2;
    chk("lap pop8 tag7", alloc_tag[7], 503);
    tick();
    chk("lap pop8 free_count", free_count, 448);
    // spec_head = 440 here: read straddles slot 447 -> 0.
    alloc_req = 12'hFFF;
    set_cmt(12'hFFF, 492);
    #2;
    for (int i = 0; i < IW; i++)
      chk($sformatf("wrap read tag[%0d]", i), alloc_tag[i], (i < 8) ? 504 + i : i - 8);
    tick();
    chk("wrap free_count", free_count, 448);
    // Lap two: pop without frees until spec_head returns to 440.
    set_cmt(12'h000, 0);
    alloc_req = 12'hFFF;
    for (int g = 0; g < 36; g++) tick();
    alloc_req = 12'h00F;
    tick();
    chk("lap2 free_count", free_count, 12);
    chk("lap2 alloc_ready", alloc_ready, 1);
    alloc_req = 12'hFFF;
    #2;
    for (int i = 0; i < IW; i++)
      chk($sformatf("wrap write tag[%0d]", i), alloc_tag[i], 492 + i);
    tick();
    chk("lap2 end free_count", free_count, 0);
    chk("lap2 end alloc_ready", alloc_ready, 0);
    alloc_req = 12'h000;

`ifdef SUPERH16_FREELIST_CHECK_EN
    // Returning a tag that is still on the list sets the sticky error.
    do_reset();
    chk("chk rst err", double_free_err, 0);
    set_cmt(12'h001, 100);
    #2;
    chk("chk same cycle err", double_free_err, 0);
    tick();
    set_cmt(12'h000, 0);
    chk("chk err set", double_free_err, 1);
    repeat (3) tick();
    chk("chk err sticky", double_free_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("chk err cleared by reset", double_free_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
